// File: rtl/alu_shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shift_sequencer_pkg
//  Description : Shared definitions for the iterative shift sequencer:
//                shift op codes, FSM state codes and the helper that sizes
//                the per-cycle shift amount from STEP.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_shift_sequencer_pkg;

    // Shift operation codes as presented on req_op.
    localparam logic [1:0] kSAIL_SHIFTSEQ_OP_SLL  = 2'b00;
    localparam logic [1:0] kSAIL_SHIFTSEQ_OP_SRL  = 2'b01;
    localparam logic [1:0] kSAIL_SHIFTSEQ_OP_SRA  = 2'b10;
    localparam logic [1:0] kSAIL_SHIFTSEQ_OP_RSVD = 2'b11;

    // Sequencer state codes (2-bit binary).
    localparam logic [1:0] kSAIL_SHIFTSEQ_STATE_IDLE  = 2'd0;
    localparam logic [1:0] kSAIL_SHIFTSEQ_STATE_SHIFT = 2'd1;
    localparam logic [1:0] kSAIL_SHIFTSEQ_STATE_DONE  = 2'd2;

    // Width of the shift-amount field and of the remaining-bits counter.
    localparam int c_SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = kSAIL_SHIFTSEQ_OP_SLL,
        OP_SRL  = kSAIL_SHIFTSEQ_OP_SRL,
        OP_SRA  = kSAIL_SHIFTSEQ_OP_SRA,
        OP_RSVD = kSAIL_SHIFTSEQ_OP_RSVD
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = kSAIL_SHIFTSEQ_STATE_IDLE,
        S_SHIFT = kSAIL_SHIFTSEQ_STATE_SHIFT,
        S_DONE  = kSAIL_SHIFTSEQ_STATE_DONE
    } state_e;

    // Bits needed to represent a per-cycle shift of 0..step.
    function automatic int step_k_width(input int step);
        return $clog2(step + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_sequencer_shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-step shifter. Shifts acc by k bits
//                (0..STEP) according to op; reserved op passes acc through.
//  Ports       : acc         in  WIDTH  value being shifted
//                op          in  2      shift operation
//                k           in  K_W    bits to shift this step (0..STEP)
//                shifted_acc out WIDTH  result of the step
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import alu_shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]              acc,
    input  op_e                           op,
    input  logic [step_k_width(STEP)-1:0] k,
    output logic [WIDTH-1:0]              shifted_acc
);

    // k is only ever 0..STEP, so the shifter depth stays bounded by STEP.
    always_comb begin
        shifted_acc = acc;
        case (op)
            OP_SLL:  shifted_acc = acc << k;
            OP_SRL:  shifted_acc = acc >> k;
            OP_SRA:  shifted_acc = $unsigned($signed(acc) >>> k);
            default: shifted_acc = acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shift_sequencer
//  Description : Iterative SLL/SRL/SRA unit. Accepts one request, shifts the
//                operand by up to STEP bits per cycle, then holds the result
//                until the consumer takes it. STEP must be 1, 2, 4 or 8.
//  Ports       : clk          in   1      core clock
//                reset        in   1      synchronous active-high reset
//                req_valid    in   1      request present
//                req_ready    out  1      unit can accept a request
//                req_op       in   2      00 SLL, 01 SRL, 10 SRA, 11 reserved
//                req_a        in   WIDTH  operand
//                req_shamt    in   5      shift amount 0..31
//                resp_valid   out  1      result available
//                resp_ready   in   1      consumer accepts result
//                resp_result  out  WIDTH  shifted value
//                busy         out  1      operation in flight (SHIFT/DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [4:0]       req_shamt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             busy
);

    localparam int                   c_K_W      = step_k_width(STEP);
    localparam logic [c_K_W-1:0]     c_STEP_K   = c_K_W'(STEP);
    localparam logic [c_SHAMT_W-1:0] c_STEP_REM = c_SHAMT_W'(STEP);

    state_e                r_state;
    logic [WIDTH-1:0]      r_acc;
    logic [c_SHAMT_W-1:0]  r_rem;
    op_e                   r_op;

    logic [c_K_W-1:0]      w_k;
    logic [c_SHAMT_W-1:0]  w_rem_next;
    logic [WIDTH-1:0]      w_step_acc;
    logic                  w_accept;

    // k = min(STEP, rem). When rem < STEP it fits in c_K_W bits, so the
    // slice is lossless; k never exceeds rem, so rem cannot wrap.
    assign w_k        = (r_rem < c_STEP_REM) ? r_rem[c_K_W-1:0] : c_STEP_K;
    assign w_rem_next = r_rem - c_SHAMT_W'(w_k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift_step (
        .acc         (r_acc),
        .op          (r_op),
        .k           (w_k),
        .shifted_acc (w_step_acc)
    );

    // Outputs decode registered state only; reset gates req_ready so no
    // request can be taken while reset is held.
    assign req_ready   = (r_state == S_IDLE) && !reset;
    assign resp_valid  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign resp_result = r_acc;
    assign w_accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_op    <= OP_SLL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= req_a;
                        r_op  <= op_e'(req_op);
                        r_rem <= req_shamt;
                        // Zero shift and reserved op skip straight to DONE
                        // with the operand passed through unchanged.
                        if ((req_shamt == '0) || (req_op == kSAIL_SHIFTSEQ_OP_RSVD)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_step_acc;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_shift_sequencer
//  Description : Self-checking bench for alu_shift_sequencer (STEP = 4).
//                A transaction-level model predicts result and latency from
//                plain shift arithmetic; a compare process checks outputs
//                every cycle, and directed cases pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_sequencer;

    localparam int WIDTH  = 32;
    localparam int STEP_P = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        req_valid  = 1'b0;
    logic [1:0]  req_op     = 2'd0;
    logic [31:0] req_a      = '0;
    logic [4:0]  req_shamt  = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_shift_sequencer #(
        .WIDTH (WIDTH),
        .STEP  (STEP_P)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_shamt   (req_shamt),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] sh);
        case (op)
            2'd0:    return a << sh;
            2'd1:    return a >> sh;
            2'd2:    return 32'($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    // Cycles from accept edge to first cycle with resp_valid.
    function automatic int ref_latency(input logic [1:0] op, input logic [4:0] sh);
        if (op == 2'd3 || sh == 5'd0) return 1;
        return 1 + (int'(sh) + STEP_P - 1) / STEP_P;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 idle, 1 waiting out the shift cycles, 2 result held
    bit          m_known = 1'b0;
    int          m_phase = 0;
    int          m_wait  = 0;
    logic [31:0] m_exp   = '0;
    logic [31:0] m_last  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_known <= 1'b1;
            m_phase <= 0;
            m_last  <= '0;
        end else if (m_known) begin
            case (m_phase)
                0: if (req_valid) begin
                    m_exp   <= ref_shift(req_op, req_a, req_shamt);
                    m_wait  <= ref_latency(req_op, req_shamt) - 1;
                    m_phase <= (ref_latency(req_op, req_shamt) == 1) ? 2 : 1;
                end
                1: begin
                    m_wait <= m_wait - 1;
                    if (m_wait == 1) m_phase <= 2;
                end
                default: if (resp_ready) begin
                    m_phase <= 0;
                    m_last  <= m_exp;
                end
            endcase
        end
    end

    // Compare every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (m_known) begin
            chk("req_ready", 32'(req_ready), 32'(m_phase == 0 && !reset));
            chk("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            if (m_phase == 2)      chk("resp_result", resp_result, m_exp);
            else if (m_phase == 0) chk("idle_result", resp_result, m_last);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_op     = op;
            req_a      = a;
            req_shamt  = sh;
            resp_ready = 1'b0;
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=no_accept required=accept");
        end
    endtask

    // Counts cycles after the accept edge until resp_valid; drives junk
    // requests meanwhile, none of which may be taken.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom % 2);
            req_op    = 2'($urandom);
            req_a     = $urandom;
            req_shamt = 5'($urandom);
            lat++;
            if (resp_valid) return;
        end
        checks++;
        failures++;
        $display("FAIL resp_timeout actual=no_resp_valid required=resp_valid");
        lat = -1;
    endtask

    task automatic release_resp(input int hold);
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                          input int hold, output int lat, output logic [31:0] res);
        issue(op, a, sh);
        wait_valid(lat);
        res = resp_result;
        release_resp(hold);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        int          lat;
        logic [31:0] res;
    } dir_t;

    dir_t dirs[7] = '{
        '{2'd0, 32'h0000_0001, 5'd31, 9, 32'h8000_0000},
        '{2'd2, 32'h8000_0000, 5'd31, 9, 32'hFFFF_FFFF},
        '{2'd1, 32'hF000_0000, 5'd6,  3, 32'h03C0_0000},
        '{2'd0, 32'h1234_5678, 5'd0,  1, 32'h1234_5678},
        '{2'd3, 32'h1234_5678, 5'd9,  1, 32'h1234_5678},
        '{2'd2, 32'h7000_0000, 5'd4,  2, 32'h0700_0000},
        '{2'd1, 32'h8000_0000, 5'd3,  2, 32'h1000_0000}
    };

    initial begin
        int          lat;
        logic [31:0] res;
        int          bad;

        // Reset with a request held: nothing may be accepted.
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 32'h5;
        req_shamt = 5'd3;
        repeat (4) @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        chk("post_reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_result", resp_result, 32'h0);

        // Directed literal cases.
        for (int i = 0; i < 7; i++) begin
            run_op(dirs[i].op, dirs[i].a, dirs[i].sh, i % 3, lat, res);
            chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(dirs[i].lat));
            chk($sformatf("dir%0d_result", i), res, dirs[i].res);
        end

        // Stall in DONE with a new request waiting, then back-to-back accept.
        issue(2'd0, 32'h0000_00A5, 5'd5);
        wait_valid(lat);
        chk("hold_latency", 32'(lat), 32'd3);
        chk("hold_result", resp_result, 32'h0000_14A0);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_a     = 32'hFFFF_0000;
        req_shamt = 5'd8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_result", resp_result, 32'h0000_14A0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        wait_valid(lat);
        chk("b2b_latency", 32'(lat), 32'd3);
        chk("b2b_result", resp_result, 32'hFFFF_FF00);
        release_resp(0);

        // Reset during the fifth shift cycle abandons the operation.
        issue(2'd0, 32'h0000_0003, 5'd20);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (i == 5) reset = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_resp_valid", 32'(resp_valid), 32'd0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid) bad++;
        end
        chk("no_resp_after_reset", 32'(bad), 32'd0);
        run_op(2'd1, 32'hDEAD_BEEF, 5'd13, 1, lat, res);
        chk("fresh_latency", 32'(lat), 32'd5);
        chk("fresh_result", res, 32'h0006_F56D);

        // Randomized operations against the model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [4:0]  sh;
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom % 5)
                0:       sh = 5'd0;
                1:       sh = 5'(STEP_P);
                2:       sh = 5'd31;
                default: sh = 5'($urandom);
            endcase
            run_op(op, a, sh, int'($urandom % 4), lat, res);
            chk("rand_latency", 32'(lat), 32'(ref_latency(op, sh)));
            chk("rand_result", res, ref_shift(op, a, sh));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
